hazard_ctrl: RTL

Pipeline hazard and sequencing controller for the five-stage MIPS core (`mips_pipelined`). It replaces the constant-zero `stallF`/`stallD`/`FlushE`/`Forward*` registers with live control:

- EX-stage and ID-stage operand forwarding selects.
- Load-use and branch-compare stalls.
- A memory-wait FSM that freezes the pipeline while the data memory holds off `mem_ready`, with a watchdog timeout.
- Saturating stall and flush event counters for debug.

---
 rtl/mips_pkg.sv | 39 +++
 rtl/mem_wait_fsm.sv | 92 +++++++++
 rtl/hazard_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the pipeline hazard controller.
//   FWD_RF / FWD_WB / FWD_MEM : EX-stage operand forward selects.
//   memState_t                : data-memory wait FSM state encoding.
//   regMatch / fwdSel         : register-dependency helpers.
package mips_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    ERROR = 2'b10
  } memState_t;

  // True when a later stage writes the register a source operand reads.
  // Register 0 is hard-wired to zero, so it never produces a dependency.
  function automatic logic regMatch(input logic [4:0] src, input logic wen,
                                    input logic [4:0] dst);
    return (src != 5'd0) && wen && (dst == src);
  endfunction

  // EX operand select; the MEM-stage result is younger, so it takes precedence.
  function automatic logic [1:0] fwdSel(input logic [4:0] src,
                                        input logic rwM, input logic [4:0] wrM,
                                        input logic rwW, input logic [4:0] wrW);
    logic [1:0] sel;
    if (regMatch(src, rwM, wrM)) begin
      sel = FWD_MEM;
    end else if (regMatch(src, rwW, wrW)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// mem_wait_fsm: tracks an outstanding data-memory access and freezes the
// pipeline while the memory holds off mem_ready; a watchdog moves to a
// sticky ERROR state after MEM_TIMEOUT WAIT cycles.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   MemReqM     : MEM-stage instruction accesses memory
//   mem_ready   : memory completes the access this cycle
//   mem_req     : request to data memory (combinational)
//   memStall    : freeze whole pipeline (combinational)
//   mem_err     : sticky timeout flag (registered)
module mem_wait_fsm
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic MemReqM,
  input  logic mem_ready,
  output logic mem_req,
  output logic memStall,
  output logic mem_err
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

  memState_t        state;
  logic [CNT_W-1:0] waitCnt;

  // State register, watchdog counter and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      waitCnt <= {CNT_W{1'b0}};
      mem_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (MemReqM && !mem_ready) begin
            state   <= WAIT;
            waitCnt <= {CNT_W{1'b0}};
          end
        end
        WAIT: begin
          // A completion in the last allowed cycle beats the timeout.
          if (mem_ready) begin
            state <= IDLE;
          end else if (waitCnt == LAST_WAIT) begin
            state   <= ERROR;
            mem_err <= 1'b1;
          end else begin
            waitCnt <= waitCnt + CNT_W'(1);
          end
        end
        ERROR: begin
          mem_err <= 1'b1;
        end
        default: begin
          // Corrupted encoding: fail safe into the error state.
          state   <= ERROR;
          mem_err <= 1'b1;
        end
      endcase
    end
  end

  // Memory request and pipeline-freeze decode from state and handshake.
  always_comb begin
    mem_req  = 1'b0;
    memStall = 1'b0;
    case (state)
      IDLE: begin
        mem_req  = MemReqM;
        memStall = MemReqM && !mem_ready;
      end
      WAIT: begin
        mem_req  = 1'b1;
        memStall = !mem_ready;
      end
      ERROR: begin
        mem_req  = 1'b0;
        memStall = 1'b1;
      end
      default: begin
        mem_req  = 1'b0;
        memStall = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and sequencing controller for the five-stage MIPS core.
// Ports:
//   clk, reset                  : clock, asynchronous active-high reset
//   RsD, RtD, RsE, RtE          : ID / EX source registers
//   WriteRegE/M/W, RegWriteE/M/W: destination registers and write enables
//   MemtoRegE/M, BranchD        : load-in-stage flags, ID branch flag
//   MemReqM, mem_ready          : MEM-stage access and memory completion
//   mem_req                     : request to data memory
//   stallF/D/E/M, FlushE/W      : pipeline register hold / bubble controls
//   ForwardAD/BD, ForwardAE/BE  : ID comparator and EX operand forwarding
//   mem_err                     : sticky memory timeout flag
//   stall_cnt, flush_cnt        : saturating debug event counters
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         RsD,
  input  logic [4:0]         RtD,
  input  logic [4:0]         RsE,
  input  logic [4:0]         RtE,
  input  logic [4:0]         WriteRegE,
  input  logic [4:0]         WriteRegM,
  input  logic [4:0]         WriteRegW,
  input  logic               RegWriteE,
  input  logic               RegWriteM,
  input  logic               RegWriteW,
  input  logic               MemtoRegE,
  input  logic               MemtoRegM,
  input  logic               BranchD,
  input  logic               MemReqM,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               stallF,
  output logic               stallD,
  output logic               stallE,
  output logic               stallM,
  output logic               FlushE,
  output logic               FlushW,
  output logic               ForwardAD,
  output logic               ForwardBD,
  output logic [1:0]         ForwardAE,
  output logic [1:0]         ForwardBE,
  output logic               mem_err,
  output logic [COUNT_W-1:0] stall_cnt,
  output logic [COUNT_W-1:0] flush_cnt
);

  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

  logic memStall;
  logic lwStall;
  logic brStall;

  mem_wait_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_memWait (
    .clk      (clk),
    .reset    (reset),
    .MemReqM  (MemReqM),
    .mem_ready(mem_ready),
    .mem_req  (mem_req),
    .memStall (memStall),
    .mem_err  (mem_err)
  );

  // Operand forwarding for the EX ALU inputs and the ID branch comparator.
  always_comb begin
    ForwardAE = fwdSel(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
    ForwardBE = fwdSel(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
    ForwardAD = regMatch(RsD, RegWriteM, WriteRegM);
    ForwardBD = regMatch(RtD, RegWriteM, WriteRegM);
  end

  // Load-use and branch-compare dependency detection.
  always_comb begin
    lwStall = MemtoRegE && (RtE != 5'd0) && ((RtE == RsD) || (RtE == RtD));
    // Branch operands resolve in ID, so an ALU result still in EX or a load
    // still in MEM cannot be forwarded in time.
    brStall = BranchD &&
              (regMatch(RsD, RegWriteE, WriteRegE) ||
               regMatch(RtD, RegWriteE, WriteRegE) ||
               regMatch(RsD, MemtoRegM, WriteRegM) ||
               regMatch(RtD, MemtoRegM, WriteRegM));
  end

  // Stall/flush priority: a memory freeze holds everything, so the EX
  // bubble is withheld until the freeze releases.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (memStall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      FlushW = 1'b1;
    end else if (lwStall || brStall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      FlushE = 1'b1;
    end else begin
      stallF = 1'b0;
      FlushE = 1'b0;
    end
  end

  // Saturating debug counters of stall and EX-flush cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= {COUNT_W{1'b0}};
      flush_cnt <= {COUNT_W{1'b0}};
    end else begin
      if (stallF && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + COUNT_W'(1);
      end
      if (FlushE && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + COUNT_W'(1);
      end
    end
  end

endmodule
